// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared types and constants for the microwave cook-time controller:
// state encodings and BCD digit limits.
package microwave_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] MAX_SEC_TENS = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam int         NUM_DIGITS   = 4;

    function automatic logic is_bcd(input logic [3:0] code);
        return code <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/microwave_timer_ctrl_bcd_digit_down.sv
// One BCD down-counting digit: loadable, decrements when enabled, wraps from 0
// to wrap_value and reports a borrow to the next more significant digit.
module bcd_digit_down
    import microwave_timer_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec_en,
    input  logic [3:0] wrap_value,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       is_zero
);

    logic [3:0] digit_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_reg <= 4'd0;
        end else if (load) begin
            digit_reg <= load_value;
        end else if (dec_en) begin
            digit_reg <= (digit_reg == 4'd0) ? wrap_value : digit_reg - 4'd1;
        end
    end

    assign digit      = digit_reg;
    assign is_zero    = (digit_reg == 4'd0);
    assign borrow_out = dec_en & is_zero;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: keypad entry into an MM:SS BCD register,
// 1 Hz countdown, magnetron enable, done indication and door/stop handling.
module microwave_timer_ctrl
    import microwave_timer_ctrl_pkg::*;
#(
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       magnetron_on,
    output logic       done,
    output logic [2:0] state
);

    localparam logic [3:0] DONE_CNT_LAST = 4'(DONE_TICKS - 1);

    state_t                state_reg;
    logic [3:0]            done_cnt_reg;
    logic                  key_ok;
    logic                  time_zero;
    logic                  time_one;
    logic                  cook_go;
    logic                  tick_dec;
    logic                  digit_load;
    logic [3:0]            load_val [NUM_DIGITS];
    logic [3:0]            digit_q  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_vec;
    logic                  unused_top_borrow;

    assign key_ok    = key_valid & is_bcd(key_code);
    assign time_zero = &zero_vec;
    assign time_one  = (&zero_vec[NUM_DIGITS-1:1]) & (digit_q[0] == 4'd1);
    assign cook_go   = start & door_closed & ~time_zero;
    // stop_clear and door-open win over a same-cycle tick, so no decrement then
    assign tick_dec  = (state_reg == ST_COOK) & tick_1hz & door_closed & ~stop_clear;

    // Digit index 0 = sec_ones ... 3 = min_tens; a load of all zeros is a clear
    always_comb begin
        digit_load = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_val[i] = 4'd0;
        end
        case (state_reg)
            ST_IDLE: begin
                if (!stop_clear && key_ok) begin
                    digit_load  = 1'b1;
                    load_val[0] = key_code;
                end
            end
            ST_ENTRY: begin
                if (stop_clear) begin
                    digit_load = 1'b1;
                end else if (!cook_go && key_ok) begin
                    digit_load  = 1'b1;
                    load_val[0] = key_code;
                    load_val[1] = digit_q[0];
                    load_val[2] = digit_q[1];
                    load_val[3] = digit_q[2];
                end
            end
            ST_PAUSE: begin
                digit_load = stop_clear;
            end
            ST_COOK, ST_DONE: begin
                digit_load = 1'b0;
            end
            default: begin
                digit_load = 1'b1;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic dec_en;
            logic borrow;
            if (gi == 0) begin : g_first
                assign dec_en = tick_dec;
            end else begin : g_chain
                assign dec_en = g_digit[gi-1].borrow;
            end
            bcd_digit_down u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (digit_load),
                .load_value (load_val[gi]),
                .dec_en     (dec_en),
                .wrap_value ((gi == 1) ? MAX_SEC_TENS : DIGIT_MAX),
                .digit      (digit_q[gi]),
                .borrow_out (borrow),
                .is_zero    (zero_vec[gi])
            );
        end
    endgenerate

    // min_tens never underflows: COOK is only entered with a nonzero time
    assign unused_top_borrow = g_digit[NUM_DIGITS-1].borrow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            magnetron_on <= 1'b0;
            done         <= 1'b0;
            done_cnt_reg <= 4'd0;
        end else begin
            magnetron_on <= 1'b0;
            done         <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!stop_clear && key_ok) state_reg <= ST_ENTRY;
                end
                ST_ENTRY: begin
                    if (stop_clear) begin
                        state_reg <= ST_IDLE;
                    end else if (cook_go) begin
                        state_reg    <= ST_COOK;
                        magnetron_on <= 1'b1;
                    end
                end
                ST_COOK: begin
                    if (stop_clear || !door_closed) begin
                        state_reg <= ST_PAUSE;
                    end else if (tick_1hz && time_one) begin
                        state_reg    <= ST_DONE;
                        done         <= 1'b1;
                        done_cnt_reg <= 4'd0;
                    end else begin
                        magnetron_on <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (stop_clear) begin
                        state_reg <= ST_IDLE;
                    end else if (start && door_closed) begin
                        state_reg    <= ST_COOK;
                        magnetron_on <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (stop_clear || !door_closed) begin
                        state_reg <= ST_IDLE;
                    end else if (tick_1hz && done_cnt_reg == DONE_CNT_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                        if (tick_1hz) done_cnt_reg <= done_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign min_tens = digit_q[3];
    assign min_ones = digit_q[2];
    assign sec_tens = digit_q[1];
    assign sec_ones = digit_q[0];
    assign state    = state_reg;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Self-checking bench for microwave_timer_ctrl: directed scenarios with fixed
// expectations plus a randomized run against a seconds/minutes reference model.
module tb_microwave_timer_ctrl;

    localparam int DONE_TICKS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       magnetron_on, done;
    logic [2:0] state;

    int checks = 0;
    int passes = 0;

    // Reference model: time held as a plain decimal MMSS number
    int m_state = 0;
    int m_val   = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    microwave_timer_ctrl #(.DONE_TICKS(DONE_TICKS)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_closed  (door_closed),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .magnetron_on (magnetron_on),
        .done         (done),
        .state        (state)
    );

    wire [20:0] dut_vec = {min_tens, min_ones, sec_tens, sec_ones, state, magnetron_on, done};

    function automatic logic [20:0] model_vec();
        int mm = m_val / 100;
        int ss = m_val % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 3'(m_state),
                m_state == 2, m_state == 4};
    endfunction

    task automatic model_step();
        int mm, ss;
        if (reset) begin
            m_state = 0; m_val = 0; m_cnt = 0;
        end else begin
            case (m_state)
                0: if (!stop_clear && key_valid && key_code <= 9) begin
                    m_val = int'(key_code); m_state = 1;
                end
                1: if (stop_clear) begin
                    m_val = 0; m_state = 0;
                end else if (start && door_closed && m_val != 0) begin
                    m_state = 2;
                end else if (key_valid && key_code <= 9) begin
                    m_val = (m_val * 10 + int'(key_code)) % 10000;
                end
                2: if (stop_clear || !door_closed) begin
                    m_state = 3;
                end else if (tick_1hz) begin
                    mm = m_val / 100; ss = m_val % 100;
                    if (ss > 0) ss = ss - 1;
                    else begin mm = mm - 1; ss = 59; end
                    m_val = mm * 100 + ss;
                    if (m_val == 0) begin m_state = 4; m_cnt = 0; end
                end
                3: if (stop_clear) begin
                    m_val = 0; m_state = 0;
                end else if (start && door_closed) begin
                    m_state = 2;
                end
                default: if (stop_clear || !door_closed) begin
                    m_state = 0;
                end else if (tick_1hz) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == DONE_TICKS) m_state = 0;
                end
            endcase
        end
    endtask

    task automatic step(input logic r, input logic tk, input logic kv, input logic [3:0] kc,
                        input logic st, input logic sc, input logic dr);
        reset = r; tick_1hz = tk; key_valid = kv; key_code = kc;
        start = st; stop_clear = sc; door_closed = dr;
        @(posedge clk);
        model_step();
        #1;
        $display("t=%0t rst=%b tick=%b key=%b/%0d start=%b stop=%b door=%b -> %h%h:%h%h state=%0d mag=%b done=%b",
                 $time, r, tk, kv, kc, st, sc, dr, min_tens, min_ones, sec_tens, sec_ones,
                 state, magnetron_on, done);
        reset = 0; tick_1hz = 0; key_valid = 0; start = 0; stop_clear = 0;
    endtask

    task automatic key(input logic [3:0] k);   step(0, 0, 1, k, 0, 0, 1); endtask
    task automatic tick();                     step(0, 1, 0, 0, 0, 0, 1); endtask
    task automatic press_start();              step(0, 0, 0, 0, 1, 0, 1); endtask
    task automatic press_stop();               step(0, 0, 0, 0, 0, 1, 1); endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        checks++;
        if (dut_vec !== 21'h0) $display("FAIL reset_state: got %h expected %h", dut_vec, 21'h0);
        else passes++;
        key(4'hA);
        checks++;
        if (dut_vec !== 21'h0) $display("FAIL invalid_key: got %h expected %h", dut_vec, 21'h0);
        else passes++;
        press_start();
        checks++;
        if (dut_vec !== 21'h0) $display("FAIL start_at_zero: got %h expected %h", dut_vec, 21'h0);
        else passes++;
    endtask

    task automatic test_entry_cook();
        key(4'd1);
        checks++;
        if (dut_vec !== {16'h0001, 3'd1, 2'b00}) $display("FAIL first_key: got %h expected %h", dut_vec, {16'h0001, 3'd1, 2'b00});
        else passes++;
        key(4'd3); key(4'd0);
        checks++;
        if (dut_vec !== {16'h0130, 3'd1, 2'b00}) $display("FAIL entry_0130: got %h expected %h", dut_vec, {16'h0130, 3'd1, 2'b00});
        else passes++;
        press_start();
        checks++;
        if (dut_vec !== {16'h0130, 3'd2, 2'b10}) $display("FAIL start_cook: got %h expected %h", dut_vec, {16'h0130, 3'd2, 2'b10});
        else passes++;
        tick();
        checks++;
        if (dut_vec !== {16'h0129, 3'd2, 2'b10}) $display("FAIL tick_0129: got %h expected %h", dut_vec, {16'h0129, 3'd2, 2'b10});
        else passes++;
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (dut_vec !== {16'h0059, 3'd2, 2'b10}) $display("FAIL borrow_0059: got %h expected %h", dut_vec, {16'h0059, 3'd2, 2'b10});
        else passes++;
        press_stop();
        checks++;
        if (dut_vec !== {16'h0059, 3'd3, 2'b00}) $display("FAIL stop_pause: got %h expected %h", dut_vec, {16'h0059, 3'd3, 2'b00});
        else passes++;
        press_stop();
        checks++;
        if (dut_vec !== 21'h0) $display("FAIL pause_clear: got %h expected %h", dut_vec, 21'h0);
        else passes++;
    endtask

    task automatic test_shift();
        for (int k = 1; k <= 5; k++) key(4'(k));
        checks++;
        if (dut_vec !== {16'h2345, 3'd1, 2'b00}) $display("FAIL shift_2345: got %h expected %h", dut_vec, {16'h2345, 3'd1, 2'b00});
        else passes++;
        press_start();
        key(4'd7);
        checks++;
        if (dut_vec !== {16'h2345, 3'd2, 2'b10}) $display("FAIL key_in_cook: got %h expected %h", dut_vec, {16'h2345, 3'd2, 2'b10});
        else passes++;
        press_stop(); press_stop();
    endtask

    task automatic test_sec_tens_above_five();
        key(4'd9); key(4'd0);
        press_start();
        tick();
        checks++;
        if (dut_vec !== {16'h0089, 3'd2, 2'b10}) $display("FAIL tick_0089: got %h expected %h", dut_vec, {16'h0089, 3'd2, 2'b10});
        else passes++;
        press_stop(); press_stop();
    endtask

    task automatic test_pause_and_done();
        key(4'd2);
        press_start();
        step(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec !== {16'h0002, 3'd3, 2'b00}) $display("FAIL door_tick_pause: got %h expected %h", dut_vec, {16'h0002, 3'd3, 2'b00});
        else passes++;
        step(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (dut_vec !== {16'h0002, 3'd3, 2'b00}) $display("FAIL start_door_open: got %h expected %h", dut_vec, {16'h0002, 3'd3, 2'b00});
        else passes++;
        press_start();
        checks++;
        if (dut_vec !== {16'h0002, 3'd2, 2'b10}) $display("FAIL resume_cook: got %h expected %h", dut_vec, {16'h0002, 3'd2, 2'b10});
        else passes++;
        tick();
        checks++;
        if (dut_vec !== {16'h0001, 3'd2, 2'b10}) $display("FAIL tick_0001: got %h expected %h", dut_vec, {16'h0001, 3'd2, 2'b10});
        else passes++;
        tick();
        checks++;
        if (dut_vec !== {16'h0000, 3'd4, 2'b01}) $display("FAIL enter_done: got %h expected %h", dut_vec, {16'h0000, 3'd4, 2'b01});
        else passes++;
        tick(); tick();
        checks++;
        if (dut_vec !== {16'h0000, 3'd4, 2'b01}) $display("FAIL done_hold: got %h expected %h", dut_vec, {16'h0000, 3'd4, 2'b01});
        else passes++;
        tick();
        checks++;
        if (dut_vec !== 21'h0) $display("FAIL done_expire: got %h expected %h", dut_vec, 21'h0);
        else passes++;
    endtask

    task automatic test_pause_clear_start();
        key(4'd5);
        press_start();
        press_stop();
        step(0, 0, 0, 0, 1, 1, 1);
        checks++;
        if (dut_vec !== 21'h0) $display("FAIL stop_with_start: got %h expected %h", dut_vec, 21'h0);
        else passes++;
    endtask

    task automatic test_reset_in_cook();
        key(4'd9);
        press_start();
        tick();
        checks++;
        if (dut_vec !== {16'h0008, 3'd2, 2'b10}) $display("FAIL cook_0008: got %h expected %h", dut_vec, {16'h0008, 3'd2, 2'b10});
        else passes++;
        step(1, 0, 0, 0, 0, 0, 1);
        checks++;
        if (dut_vec !== 21'h0) $display("FAIL reset_in_cook: got %h expected %h", dut_vec, 21'h0);
        else passes++;
    endtask

    task automatic test_random();
        logic r, tk, kv, st, sc, dr;
        logic [3:0] kc;
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            tk = ($urandom_range(0, 99) < 50);
            kv = ($urandom_range(0, 99) < 25);
            kc = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 99) < 15);
            sc = ($urandom_range(0, 99) < 4);
            dr = ($urandom_range(0, 99) < 93);
            step(r, tk, kv, kc, st, sc, dr);
            checks++;
            if (dut_vec !== model_vec())
                $display("FAIL random_%0d: got %h expected %h", n, dut_vec, model_vec());
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_entry_cook();
        test_shift();
        test_sec_tens_above_five();
        test_pause_and_done();
        test_pause_clear_start();
        test_reset_in_cook();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
